cpu_imem: RTL and testbench
===========================

# cpu_imem

Single-cycle RV32I-subset processor core with its instruction memory, word-addressed data memory and program counter. It fetches, decodes, executes and retires one instruction per CLK edge. Wrapping programs reach it only through preloaded instruction memory and the debug/status ports. It is the compute block instantiated directly under the processor top level.

## Interface
Parameters:
- `RESET_PC`, default 32'd4: PC value loaded on reset.
- `IMEM_WORDS`, default 1024: instruction memory depth in 32-bit words.
- `DMEM_WORDS`, default 1024: data memory depth in 32-bit words.
- `IMEM_FILE`, default "imem.bin": binary image, used only with `IMEM_INIT_EN`.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST_X`, in, 1: reset, asynchronous, active-high.
- `pc`, out, 32: current program counter.
- `instr`, out, 32: instruction at `pc`.
- `halt`, out, 1: high when `pc[11:2]==0`.
- `dbg_sel`, in, 5: register-file index for debug read.
- `dbg_data`, out, 32: `x[dbg_sel]`, combinational; always 0 for index 0.

## Operation
- Instruction memory array is named `mem`, indexed by `pc[11:2]` with modulo `IMEM_WORDS`, and read combinationally. Benches may preload it hierarchically as `imem.mem[i]`.
- Register file: x0..x31, two combinational read ports, one write port. Writes to x0 are discarded.
- Supported opcodes:
  - OP (0110011): ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI.
  - LOAD (0000011): LW only.
  - STORE (0100011): SW only.
  - BRANCH (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111).
- Immediates are sign-extended per the I/S/B/U/J formats.
- All arithmetic is 32-bit wrap-around. Shifts use `rhs[4:0]`.
- Data memory address is the ALU sum `rs1+imm`, indexed by `addr[11:2]` modulo `DMEM_WORDS`. Negative addresses therefore wrap: 0xFFFFFFFC maps to the last word. Low two address bits are ignored.
- Next-PC selection:
  - Default: `pc+4`.
  - Taken branch: `pc+imm`.
  - JAL: `pc+imm`.
  - JALR: `(rs1+imm) & ~1`.
- rd write-back value:
  - JAL/JALR: `pc+4`.
  - LW: the loaded word.
  - All others: the ALU result.
- Undefined opcodes or funct fields execute as NOP: no register or memory write, next PC is `pc+4`.
- `halt` does not stop the clock. The enclosing bench terminates on it. Word 0 conventionally holds a NOP.

## Timing
- Fully single-cycle. Fetch, decode, register read, ALU and memory read are combinational within one cycle.
- On each rising CLK edge with reset low, `pc`, the rd write and the SW write commit together.
- A register written at edge N is visible to the instruction executing after edge N. There are no hazards and no stalls.
- Reset state:
  - `pc` = `RESET_PC`.
  - x1..x31 = 0.
  - `halt` = 0 when `RESET_PC` = 4.
  - Data memory is not cleared.
- Reset mid-operation discards the in-flight instruction; its write is suppressed.
- `halt` asserts combinationally in the cycle `pc` enters 0..3.

## Configuration
- `IMEM_INIT_EN` defined: an initial block runs `$readmemb(IMEM_FILE, mem)`.
- `IMEM_INIT_EN` undefined: `mem` powers up as X, and contents come only from hierarchical preload.

## Test plan
- Arithmetic: preload `addi x5,x0,-48`, `addi x6,x0,42`, `add x7,x5,x6` from word 1. After 3 cycles, x5=-48, x6=42, x7=-6.
- Stack push: `sw x1,0(x2)` then `addi x2,x2,-4` with x1=0, x2=0. Required: dmem word `0` = 0, x2=0xFFFFFFFC. A following `sw` writes dmem word `DMEM_WORDS-1`.
- Call and return: `jal x1,+32` at pc 72. Required: x1=76, next pc=104. Then `jalr x0,0(x1)` returns to pc 76.
- Load and x0 rule: store 42 to a word, then `lw x1` from the same address, so x1=42. `addi x0,x0,5` leaves x0=0, and `dbg_sel=0` returns 0.
- Halt and reset: `jalr x0,0(x1)` with x1=0 drives pc=0 and `halt`=1. Asserting RST_X mid-program forces pc=4 and x1..x31=0 immediately, without a clock edge.
- Branch: `beq` with equal operands jumps to `pc+imm`. With unequal operands, pc advances by 4 and no register changes.

Source files
------------

// File: rtl/cpu_imem.sv
// cpu_imem: single-cycle RV32I-subset core with instruction memory, data memory and PC.
module cpu_imem #(
  parameter logic [31:0] RESET_PC   = 32'd4,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter string       IMEM_FILE  = "imem.bin"
) (
  input  logic        CLK,
  input  logic        RST_X,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        halt,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  localparam int unsigned ImemAw = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DmemAw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [1:0] {WbAlu, WbLoad, WbLink} wb_sel_e;

  typedef enum logic [1:0] {PcPlus4, PcBranch, PcJal, PcJalr} pc_sel_e;

  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  logic [31:0] mem  [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] pc_q, pc_d;

  // Fetch
  logic [ImemAw-1:0] imem_idx;
  assign imem_idx = ImemAw'(32'(pc_q[11:2]) % IMEM_WORDS);
  assign instr    = mem[imem_idx];
  assign pc       = pc_q;
  assign halt     = (pc_q[11:2] == 10'd0);

  // Decode fields and immediates
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_val  = rf_q[rs1];
  assign rs2_val  = rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf_q[dbg_sel];

  // Control decode; anything unrecognised leaves every write disabled (NOP)
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  pc_sel_e     pc_sel;
  logic [31:0] alu_a, alu_b;
  logic        rd_we, dmem_we;

  always_comb begin
    alu_op  = AluAdd;
    alu_a   = rs1_val;
    alu_b   = imm_i;
    wb_sel  = WbAlu;
    pc_sel  = PcPlus4;
    rd_we   = 1'b0;
    dmem_we = 1'b0;
    case (opcode)
      OpcOp: begin
        alu_b  = rs2_val;
        alu_op = f3_alu(funct3, funct7[5]);
        rd_we  = (funct7 == 7'b0000000) ||
                 (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OpcOpImm: begin
        // Only shifts carry a funct7; SRAI is selected by bit 30
        alu_op = f3_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  rd_we = (funct7 == 7'b0000000);
          3'b101:  rd_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: rd_we = 1'b1;
        endcase
      end
      OpcLoad: begin
        rd_we  = (funct3 == 3'b010);
        wb_sel = WbLoad;
      end
      OpcStore: begin
        alu_b   = imm_s;
        dmem_we = (funct3 == 3'b010);
      end
      OpcBranch: pc_sel = PcBranch;
      OpcJal: begin
        rd_we  = 1'b1;
        wb_sel = WbLink;
        pc_sel = PcJal;
      end
      OpcJalr: begin
        if (funct3 == 3'b000) begin
          rd_we  = 1'b1;
          wb_sel = WbLink;
          pc_sel = PcJalr;
        end
      end
      OpcLui: begin
        rd_we = 1'b1;
        alu_a = 32'd0;
        alu_b = imm_u;
      end
      OpcAuipc: begin
        rd_we = 1'b1;
        alu_a = pc_q;
        alu_b = imm_u;
      end
      default: ;
    endcase
  end

  // ALU
  logic [31:0] alu_res;

  always_comb begin
    alu_res = alu_a + alu_b;
    case (alu_op)
      AluSub:  alu_res = alu_a - alu_b;
      AluSll:  alu_res = alu_a << alu_b[4:0];
      AluSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      AluSltu: alu_res = {31'd0, alu_a < alu_b};
      AluXor:  alu_res = alu_a ^ alu_b;
      AluSrl:  alu_res = alu_a >> alu_b[4:0];
      AluSra:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      AluOr:   alu_res = alu_a | alu_b;
      AluAnd:  alu_res = alu_a & alu_b;
      default: ;
    endcase
  end

  // Branch condition; reserved funct3 encodings never branch
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    case (pc_sel)
      PcBranch: if (br_taken) pc_d = pc_q + imm_b;
      PcJal:    pc_d = pc_q + imm_j;
      PcJalr:   pc_d = {alu_res[31:1], 1'b0};
      default:  ;
    endcase
  end

  // Data memory: word index wraps, so negative addresses land at the top
  logic [DmemAw-1:0] dmem_idx;
  logic [31:0]       load_data, wb_val;

  assign dmem_idx  = DmemAw'(32'(alu_res[11:2]) % DMEM_WORDS);
  assign load_data = dmem[dmem_idx];

  always_comb begin
    case (wb_sel)
      WbLoad:  wb_val = load_data;
      WbLink:  wb_val = pc_plus4;
      default: wb_val = alu_res;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (rd_we && rd != 5'd0) rf_d[rd] = wb_val;
  end

  always_ff @(posedge CLK or posedge RST_X) begin
    if (RST_X) begin
      pc_q <= RESET_PC;
      rf_q <= '{default: '0};
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  // Not cleared by reset; a store in a reset cycle is dropped
  always_ff @(posedge CLK) begin
    if (!RST_X && dmem_we) dmem[dmem_idx] <= rs2_val;
  end

endmodule

// File: tb/tb_cpu_imem.sv
// Bench for cpu_imem: directed programs plus random programs checked against an
// instruction-level reference model of the RV32I subset.
`timescale 1ns/1ps
module tb_cpu_imem;

  localparam int unsigned Words = 1024;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [31:0] pc, instr, dbg_data;
  logic        halt;
  logic [4:0]  dbg_sel;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_imem [Words];
  logic [31:0] m_dmem [Words];
  logic [31:0] m_rf   [32];
  logic [31:0] m_pc;

  cpu_imem #(
    .RESET_PC  (32'd4),
    .IMEM_WORDS(Words),
    .DMEM_WORDS(Words),
    .IMEM_FILE ("imem.bin")
  ) imem (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .pc      (pc),
    .instr   (instr),
    .halt    (halt),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  always #50 CLK = ~CLK;

  // Encoders
  function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Reference model
  function automatic logic [31:0] alu(logic [2:0] f3, logic alt, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) return sa >>> b[4:0];
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int didx(logic [31:0] addr);
    return int'(addr[11:2]) % Words;
  endfunction

  task automatic model_reset();
    m_pc = 32'd4;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, res, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wr, tk;
    ins = m_imem[m_pc[11:2]];
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = m_rf[ins[19:15]];
    b  = m_rf[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4; wr = 1'b0; res = 32'd0; tk = 1'b0;
    case (op)
      7'b0110011:
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          wr = 1'b1; res = alu(f3, f7[5], a, b);
        end
      7'b0010011:
        if (!(f3 == 3'd1 && f7 != 7'h00) && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
          wr = 1'b1; res = alu(f3, f3 == 3'd5 && f7[5], a, ii);
        end
      7'b0000011: if (f3 == 3'd2) begin wr = 1'b1; res = m_dmem[didx(a + ii)]; end
      7'b0100011: if (f3 == 3'd2) m_dmem[didx(a + is)] = b;
      7'b1100011: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ij; end
      7'b1100111:
        if (f3 == 3'd0) begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + ii) & ~32'd1; end
      7'b0110111: begin wr = 1'b1; res = iu; end
      7'b0010111: begin wr = 1'b1; res = m_pc + iu; end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_rf[rd] = res;
    m_pc = nxt;
  endtask

  // Checking helpers
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(logic [4:0] idx, output logic [31:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic chk_regs(string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      rd_reg(5'(i), v);
      chk($sformatf("%s x%0d", tag, i), v, m_rf[i]);
    end
  endtask

  task automatic chk_pc(string tag);
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " halt"}, {31'd0, halt}, {31'd0, m_pc[11:2] == 10'd0});
  endtask

  task automatic step(int n, string tag);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
      chk_pc(tag);
    end
  endtask

  task automatic put(int w, logic [31:0] ins);
    imem.mem[w] = ins;
    m_imem[w]   = ins;
  endtask

  task automatic reset_dut();
    RST_X = 1'b1;
    model_reset();
    #1;
    chk("reset pc", pc, 32'd4);
    @(negedge CLK);
    RST_X = 1'b0;
  endtask

  function automatic logic [6:0] rand_f7();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 7'($urandom);
    return (r < 3) ? 7'h20 : 7'h00;
  endfunction

  function automatic logic [31:0] gen_rand();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    imm = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: return enc_r(rand_f7(), rs2, rs1, f3, rd);
      3, 4: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = rand_f7();
        return enc_i(imm, rs1, f3, rd, 7'b0010011);
      end
      5: return {imm[31:12], rd, ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111};
      6: return enc_s(imm, rs2, 5'd0);
      7: return enc_i(imm, 5'd0, 3'b010, rd, 7'b0000011);
      8: return enc_b(32'd8, rs2, rs1, f3);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] v;

  initial begin
    RST_X   = 1'b1;
    dbg_sel = 5'd0;
    for (int i = 0; i < Words; i++) put(i, Nop);
    model_reset();
    #1;
    chk("reset pc", pc, 32'd4);
    chk("reset halt", {31'd0, halt}, 32'd0);
    chk_regs("reset");
    @(negedge CLK);
    RST_X = 1'b0;

    // Arithmetic
    put(1, enc_i(-32'sd48, 5'd0, 3'd0, 5'd5, 7'b0010011));
    put(2, enc_i(32'd42, 5'd0, 3'd0, 5'd6, 7'b0010011));
    put(3, enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7));
    reset_dut();
    step(3, "arith");
    rd_reg(5'd5, v); chk("arith x5", v, 32'hFFFF_FFD0);
    rd_reg(5'd6, v); chk("arith x6", v, 32'd42);
    rd_reg(5'd7, v); chk("arith x7", v, 32'hFFFF_FFFA);
    chk_regs("arith");

    // Load and x0
    put(1, enc_i(32'd42, 5'd0, 3'd0, 5'd3, 7'b0010011));
    put(2, enc_s(32'd0, 5'd3, 5'd0));
    put(3, enc_i(32'd0, 5'd0, 3'b010, 5'd1, 7'b0000011));
    put(4, enc_i(32'd5, 5'd0, 3'd0, 5'd0, 7'b0010011));
    reset_dut();
    step(4, "load");
    rd_reg(5'd1, v); chk("load x1", v, 32'd42);
    rd_reg(5'd0, v); chk("x0 stays zero", v, 32'd0);
    chk("load dmem0", imem.dmem[0], 32'd42);

    // Stack push with wrap below address 0
    put(1, enc_i(32'd99, 5'd0, 3'd0, 5'd6, 7'b0010011));
    put(2, enc_s(32'd0, 5'd1, 5'd2));
    put(3, enc_i(-32'sd4, 5'd2, 3'd0, 5'd2, 7'b0010011));
    put(4, enc_s(32'd0, 5'd6, 5'd2));
    reset_dut();
    step(4, "stack");
    chk("stack dmem0", imem.dmem[0], 32'd0);
    rd_reg(5'd2, v); chk("stack x2", v, 32'hFFFF_FFFC);
    chk("stack dmem top", imem.dmem[Words-1], 32'd99);
    chk("stack model top", imem.dmem[Words-1], m_dmem[Words-1]);

    // Call and return
    put(1, enc_j(32'd68, 5'd0));
    put(18, enc_j(32'd32, 5'd1));
    put(26, enc_i(32'd0, 5'd1, 3'd0, 5'd0, 7'b1100111));
    reset_dut();
    step(1, "call pre");
    chk("call at 72", pc, 32'd72);
    step(1, "call");
    chk("call pc", pc, 32'd104);
    rd_reg(5'd1, v); chk("call x1", v, 32'd76);
    step(1, "ret");
    chk("ret pc", pc, 32'd76);

    // Halt via jalr to 0
    put(1, enc_i(32'd0, 5'd1, 3'd0, 5'd0, 7'b1100111));
    reset_dut();
    step(1, "halt");
    chk("halt pc", pc, 32'd0);
    chk("halt flag", {31'd0, halt}, 32'd1);
    step(1, "after halt");

    // Asynchronous reset mid-program, held across an edge
    put(1, enc_i(-32'sd48, 5'd0, 3'd0, 5'd5, 7'b0010011));
    put(2, enc_i(32'd42, 5'd0, 3'd0, 5'd6, 7'b0010011));
    put(3, enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7));
    reset_dut();
    step(2, "pre rst");
    #20;
    RST_X = 1'b1;
    model_reset();
    #1;
    chk("async rst pc", pc, 32'd4);
    rd_reg(5'd5, v); chk("async rst x5", v, 32'd0);
    chk_regs("async rst");
    @(posedge CLK);
    #1;
    rd_reg(5'd5, v); chk("rst held x5", v, 32'd0);
    chk("rst held pc", pc, 32'd4);
    @(negedge CLK);
    RST_X = 1'b0;
    step(3, "post rst");
    rd_reg(5'd7, v); chk("post rst x7", v, 32'hFFFF_FFFA);

    // Branches
    put(1, enc_i(32'd7, 5'd0, 3'd0, 5'd5, 7'b0010011));
    put(2, enc_i(32'd7, 5'd0, 3'd0, 5'd6, 7'b0010011));
    put(3, enc_b(32'd16, 5'd6, 5'd5, 3'd0));
    put(7, enc_i(32'd8, 5'd0, 3'd0, 5'd6, 7'b0010011));
    put(8, enc_b(32'd16, 5'd6, 5'd5, 3'd0));
    reset_dut();
    step(3, "beq taken");
    chk("beq taken pc", pc, 32'd28);
    step(1, "setup");
    step(1, "beq not taken");
    chk("beq not taken pc", pc, 32'd36);
    chk_regs("branch");

    // Random programs
    for (int r = 0; r < 4; r++) begin
      for (int w = 1; w <= 60; w++) put(w, gen_rand());
      reset_dut();
      step(60, $sformatf("rand%0d", r));
      chk_regs($sformatf("rand%0d", r));
      for (int i = 0; i < Words; i++)
        chk($sformatf("rand%0d dmem%0d", r, i), imem.dmem[i], m_dmem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
